// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline hazard/control unit.
//   hazard_entry_t : one in-flight writer {valid, dst, load}
//   FWD_REGFILE    : forwarding-select value meaning "use the register file"
//   DEF_*          : default configuration widths/depths
// The entry's dst field is sized for the largest supported register file so
// one typedef serves every REG_ADDR_W; narrower indices are zero-extended.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int DEF_NUM_REGS     = 32;
    localparam int DEF_REG_ADDR_W   = 5;
    localparam int DEF_DEPTH        = 3;
    localparam int DEF_LOAD_READY   = 1;
    localparam int DEF_BRANCH_FLUSH = 2;

    localparam int MAX_REG_ADDR_W   = 8;
    localparam int FWD_REGFILE      = 0;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] dst;
        logic                      load;
    } hazard_entry_t;

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Priority match of one decode source register against the tracking array.
// The youngest (lowest index) valid entry whose dst equals the source wins.
// Ports:
//   entries  in   tracking array, index 0 = X (youngest)
//   src      in   source register index
//   enable   in   source is real: instruction valid and source actually read
//   hit      out  a matching in-flight writer exists
//   k        out  index of the youngest matching entry
//   is_load  out  the matching writer is a load
// Register 0 never matches.
// -----------------------------------------------------------------------------
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int K_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  hazard_entry_t         entries [DEPTH],
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  enable,
    output logic                  hit,
    output logic [K_W-1:0]        k,
    output logic                  is_load
);

    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        if (enable && (src != '0)) begin
            // Scan oldest to youngest so the youngest match is written last.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entries[i].valid && (entries[i].dst == MAX_REG_ADDR_W'(src))) begin
                    hit     = 1'b1;
                    k       = K_W'(i);
                    is_load = entries[i].load;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and pipeline-control unit beside the decode stage of an in-order
// pipeline. Tracks in-flight writers in the DEPTH post-decode stages and
// produces stall, flush and per-source forwarding selects.
// Configuration macro: FORWARDING_EN
//   defined   : forwarding selects active, only early load-use stalls
//   undefined : fwd_sel tied to 0, any in-flight match stalls
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   d_valid                      decode holds a real instruction
//   d_src_reg_1/2, d_use_1/2     decode sources and their read enables
//   d_dst_reg, d_reg_write       decode destination and write enable
//   d_mem_read                   decode instruction is a load
//   x_redirect                   execute resolved a taken branch/jump
//   stall                        hold PC and f2d, bubble d2x
//   flush                        squash f2d and d2x
//   fwd_sel_1/2                  0 = register file, k = tracking entry k-1
//   stall_count                  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int   NUM_REGS     = DEF_NUM_REGS,
    parameter int   REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int   DEPTH        = DEF_DEPTH,
    parameter int   LOAD_READY   = DEF_LOAD_READY,
    parameter int   BRANCH_FLUSH = DEF_BRANCH_FLUSH,
    localparam int  FWD_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_src_reg_1,
    input  logic [REG_ADDR_W-1:0] d_src_reg_2,
    input  logic                  d_use_1,
    input  logic                  d_use_2,
    input  logic [REG_ADDR_W-1:0] d_dst_reg,
    input  logic                  d_reg_write,
    input  logic                  d_mem_read,
    input  logic                  x_redirect,
    output logic                  stall,
    output logic                  flush,
    output logic [FWD_W-1:0]      fwd_sel_1,
    output logic [FWD_W-1:0]      fwd_sel_2,
    output logic [31:0]           stall_count
);

    localparam int K_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FC_W = $clog2(BRANCH_FLUSH + 1);

    hazard_entry_t    entry_q [DEPTH];
    logic [FC_W-1:0]  flush_cnt;
    logic [31:0]      stall_cnt_q;

    logic             hit_1, hit_2;
    logic [K_W-1:0]   k_1, k_2;
    logic             load_1, load_2;
    logic             haz_1, haz_2;
    logic [FWD_W-1:0] fwd_1, fwd_2;
    logic             insert;

    hazard_match #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .K_W        (K_W)
    ) u_match_1 (
        .entries (entry_q),
        .src     (d_src_reg_1),
        .enable  (d_valid && d_use_1),
        .hit     (hit_1),
        .k       (k_1),
        .is_load (load_1)
    );

    hazard_match #(
        .DEPTH      (DEPTH),
        .REG_ADDR_W (REG_ADDR_W),
        .K_W        (K_W)
    ) u_match_2 (
        .entries (entry_q),
        .src     (d_src_reg_2),
        .enable  (d_valid && d_use_2),
        .hit     (hit_2),
        .k       (k_2),
        .is_load (load_2)
    );

`ifdef FORWARDING_EN
    // A load whose data is not yet available at index k must wait; every
    // other writer is forwarded from its tracking entry.
    assign haz_1 = hit_1 && load_1 && (int'(k_1) < LOAD_READY);
    assign haz_2 = hit_2 && load_2 && (int'(k_2) < LOAD_READY);
    assign fwd_1 = (hit_1 && !haz_1) ? FWD_W'(k_1) + FWD_W'(1) : FWD_W'(FWD_REGFILE);
    assign fwd_2 = (hit_2 && !haz_2) ? FWD_W'(k_2) + FWD_W'(1) : FWD_W'(FWD_REGFILE);

    logic unused_cfg;
    assign unused_cfg = NUM_REGS[0];
`else
    // No bypass network: wait until the writer has retired.
    assign haz_1 = hit_1;
    assign haz_2 = hit_2;
    assign fwd_1 = FWD_W'(FWD_REGFILE);
    assign fwd_2 = FWD_W'(FWD_REGFILE);

    logic unused_cfg;
    assign unused_cfg = ^{NUM_REGS[0], LOAD_READY[0], k_1, k_2, load_1, load_2};
`endif

    // Outputs are gated by reset so they are quiet while reset is held,
    // even with decode/execute inputs active.
    assign flush     = reset && (x_redirect || (flush_cnt != '0));
    assign stall     = reset && !flush && (haz_1 || haz_2);
    assign fwd_sel_1 = reset ? fwd_1 : FWD_W'(FWD_REGFILE);
    assign fwd_sel_2 = reset ? fwd_2 : FWD_W'(FWD_REGFILE);

    assign stall_count = stall_cnt_q;

    assign insert = d_valid && d_reg_write && (d_dst_reg != '0) && !stall && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            flush_cnt   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (insert) begin
                entry_q[0] <= '{valid: 1'b1,
                                dst:   MAX_REG_ADDR_W'(d_dst_reg),
                                load:  d_mem_read};
            end else begin
                entry_q[0] <= '0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                entry_q[i] <= entry_q[i-1];
            end

            // Redirects from wrong-path instructions are ignored while
            // a flush window is already open.
            if (x_redirect && (flush_cnt == '0)) begin
                flush_cnt <= FC_W'(BRANCH_FLUSH - 1);
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FC_W'(1);
            end

            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule
